icache: RTL and testbench

Direct-mapped, one-word-per-frame instruction cache placed between each core's fetch stage and the coherence/arbitration memory controller. It serves fetch-stage reads combinationally on a hit. On a miss it issues a single-word instruction fetch (`iREN`/`iaddr`/`iwait`/`iload`) to the memory controller and installs the returned word. Instruction space is read-only, so there is no write-back, no dirty state and no coherence participation.

---
 rtl/icache.sv | 167 ++++++++++++++++
 tb/tb_icache.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache -- direct-mapped, one-word-per-frame instruction cache.
//
// Sits between the fetch stage and the memory controller. A hit is answered
// combinationally. A miss issues a single-word fetch (iREN/iaddr, handshake
// on iwait/iload) and installs the returned word. Instruction space is
// read-only, so there is no write-back or dirty state.
//
// Optional feature: define ICACHE_PREFETCH_EN to enable next-line prefetch.
// After each demand fill of A, A+4 is fetched unless it is already resident.
//
// Ports:
//   CLK, nRST           clock (rising edge), async active-low reset
//   imemREN, imemaddr   fetch-stage read request and byte address
//   iflush              invalidate every frame
//   ihit, imemload      request satisfied this cycle, instruction word (0 on no hit)
//   iREN, iaddr         fetch request / word address to the memory controller
//   iwait, iload        controller busy (0 = iload valid), returned word
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int IDX = $clog2(SETS);
    localparam int TW  = 30 - IDX;

`ifdef ICACHE_PREFETCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MISS = 2'd1, PREFETCH = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MISS = 2'd1} state_t;
`endif

    state_t state, next_state;

    logic [SETS-1:0] valid;
    logic [TW-1:0]   tags  [SETS];
    logic [31:0]     words [SETS];

    logic [31:0]     miss_addr;
    logic            flush_pend;

    logic [IDX-1:0]  req_idx;
    logic [TW-1:0]   req_tag;
    logic            lookup_ok;
    logic            fill_en;
    logic [31:0]     fill_addr;
    logic [IDX-1:0]  fill_idx;
    logic            fill_done;
    logic            flush_now;
    logic            unused_bits;

    assign req_idx  = imemaddr[IDX+1:2];
    assign req_tag  = imemaddr[31:IDX+2];
    assign fill_idx = fill_addr[IDX+1:2];

    assign unused_bits = ^{imemaddr[1:0], fill_addr[1:0]};

`ifdef ICACHE_PREFETCH_EN
    logic [31:0]    pf_addr;
    logic [31:0]    pf_next;
    logic [IDX-1:0] pf_idx;
    logic           pf_present;

    assign lookup_ok = (state == IDLE) || (state == PREFETCH);
    assign pf_next   = miss_addr + 32'd4;   // natural 32-bit wrap
    assign pf_idx    = pf_next[IDX+1:2];
    // pf_idx never equals the frame being filled (SETS >= 2), so the
    // current valid/tag are the right view -- except that a flush on this
    // same edge wipes the line, in which case it must be fetched.
    assign pf_present = valid[pf_idx] && (tags[pf_idx] == pf_next[31:IDX+2]) && !flush_now;
`else
    assign lookup_ok = (state == IDLE);
`endif

    assign ihit     = imemREN && lookup_ok && valid[req_idx] && (tags[req_idx] == req_tag);
    assign imemload = ihit ? words[req_idx] : 32'd0;

    // A fill lands on any edge where an outstanding fetch sees iwait low.
    assign fill_done = (state != IDLE) && !iwait;
    // In IDLE a flush applies directly; otherwise it is held until the fill
    // completes and then applied after the install so the flush wins.
    assign flush_now = (state == IDLE) ? iflush : (fill_done && (flush_pend || iflush));

    always_comb begin
        next_state = state;
        fill_en    = 1'b0;
        fill_addr  = miss_addr;
        iREN       = 1'b0;
        iaddr      = miss_addr;
        case (state)
            IDLE: begin
                if (imemREN && !ihit) next_state = MISS;
            end
            MISS: begin
                iREN = 1'b1;
                if (!iwait) begin
                    fill_en    = 1'b1;
                    next_state = IDLE;
`ifdef ICACHE_PREFETCH_EN
                    if (!pf_present) next_state = PREFETCH;
`endif
                end
            end
`ifdef ICACHE_PREFETCH_EN
            PREFETCH: begin
                // Demand misses are not latched here; they re-evaluate in IDLE.
                iREN      = 1'b1;
                iaddr     = pf_addr;
                fill_addr = pf_addr;
                if (!iwait) begin
                    fill_en    = 1'b1;
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_addr  <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && imemREN && !ihit)
                miss_addr <= {imemaddr[31:2], 2'b00};
            if (fill_en)
                valid[fill_idx] <= 1'b1;
            if (flush_now)
                valid <= '0;            // after the install: flush wins
            if (fill_en)
                flush_pend <= 1'b0;
            else if (state != IDLE && iflush)
                flush_pend <= 1'b1;
        end
    end

`ifdef ICACHE_PREFETCH_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            pf_addr <= '0;
        else if (state == MISS && !iwait)
            pf_addr <= pf_next;
    end
`endif

    // Tag/data arrays need no reset; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tags[fill_idx]  <= fill_addr[31:IDX+2];
            words[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;
    localparam int SETS = 16;
`ifdef ICACHE_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'd0;
    logic        iflush = 1'b0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'd0;

    icache #(.SETS(SETS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .iflush(iflush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        hit;
    } resp_t;

    resp_t       resp_q[$];
    logic [31:0] fetch_q[$];
    logic [31:0] mem [logic [31:0]];
    bit          mv [SETS];
    logic [31:0] ma [SETS];
    int          forced_waits = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
    endfunction

    // Reference model: each frame remembers the full word address it holds.
    function automatic int frame(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        logic [31:0] aw;
        aw = a & ~32'd3;
        return mv[frame(aw)] && (ma[frame(aw)] == aw);
    endfunction

    function automatic void m_fill(input logic [31:0] aw);
        fetch_q.push_back(aw);
        mv[frame(aw)] = 1'b1;
        ma[frame(aw)] = aw;
    endfunction

    function automatic void m_flush();
        foreach (mv[i]) mv[i] = 1'b0;
    endfunction

    function automatic void m_prefetch(input logic [31:0] aw);
        logic [31:0] pf;
        pf = aw + 32'd4;
        if (PF && !m_hit(pf)) m_fill(pf);
    endfunction

    // Demand fetch held until ihit; returns cycles with iREN high before the hit.
    task automatic fetch(input logic [31:0] a, output int ren_cycles);
        logic [31:0] aw;
        bit h;
        int n;
        aw = {a[31:2], 2'b00};
        h  = m_hit(a);
        if (!h) begin
            m_fill(aw);
            m_prefetch(aw);
        end
        resp_q.push_back({mem_word(aw), h});
        @(posedge CLK); #1;
        imemREN = 1'b1; imemaddr = a;
        ren_cycles = 0; n = 0;
        forever begin
            @(negedge CLK);
            if (ihit) break;
            if (iREN) ren_cycles++;
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL fetch_timeout: addr %h got no ihit expected ihit within 60 cycles", a);
                break;
            end
        end
        @(posedge CLK); #1;
        imemREN = 1'b0; imemaddr = $urandom;
        if (!h) repeat (6) @(posedge CLK);
    endtask

    task automatic flush_idle();
        @(posedge CLK); #1 iflush = 1'b1;
        @(posedge CLK); #1 iflush = 1'b0;
        m_flush();
    endtask

    // One-cycle demand that is known to miss; leaves the cache in MISS.
    task automatic miss_pulse(input logic [31:0] a);
        @(posedge CLK); #1 imemREN = 1'b1; imemaddr = a;
        @(posedge CLK); #1 imemREN = 1'b0;
    endtask

    // Monitor: pops an expected response for every ihit.
    initial begin : mon
        int lat;
        resp_t r;
        lat = 0;
        forever begin
            @(negedge CLK);
            if (ihit) begin
                chk("hit_needs_req", 32'(imemREN), 32'd1);
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_hit: got ihit addr %h expected none", imemaddr);
                end else begin
                    r = resp_q.pop_front();
                    chk("hit_data", imemload, r.data);
                    chk("hit_zero_latency", 32'(lat == 0), 32'(r.hit));
                end
                lat = 0;
            end else begin
                chk("load_zero_no_hit", imemload, 32'd0);
                lat = imemREN ? lat + 1 : 0;
            end
        end
    end

    // Memory controller model: answers each fetch after a chosen wait.
    initial begin : ctrl
        bit busy;
        int wleft;
        logic [31:0] cur;
        busy = 1'b0; wleft = 0; cur = 32'd0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                busy = 1'b0; iwait = 1'b1;
            end else begin
                if (busy) begin
                    chk("iren_held", 32'(iREN), 32'd1);
                    chk("iaddr_stable", iaddr, cur);
                end else if (iREN) begin
                    cur  = iaddr;
                    busy = 1'b1;
                    if (fetch_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_fetch: got iaddr %h expected no fetch", iaddr);
                    end else begin
                        chk("fetch_addr", iaddr, fetch_q.pop_front());
                    end
                    wleft = (forced_waits >= 0) ? forced_waits : int'($urandom_range(0, 3));
                end
                if (busy) begin
                    if (wleft == 0) begin
                        iwait = 1'b0; iload = mem_word(cur); busy = 1'b0;
                    end else begin
                        iwait = 1'b1; iload = $urandom; wleft--;
                    end
                end else begin
                    iwait = 1'b1; iload = $urandom;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : drive
        int n;
        logic [31:0] pool [4];
        logic [31:0] a;
        pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0400;
        pool[2] = 32'h1234_5600; pool[3] = 32'hFFFF_FFC0;
        m_flush();

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iren", 32'(iREN), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_iren", 32'(iREN), 32'd0);

        // cold miss with 3 wait cycles
        mem[32'h40] = 32'h8C01_0004;
        forced_waits = 3;
        fetch(32'h40, n);
        chk("cold_iren_cycles", n, 32'd4);
        forced_waits = -1;

        // conflict eviction at index 0
        fetch(32'h40, n);
        chk("warm_hit_no_fetch", n, 32'd0);
        fetch(32'h80, n);
        chk("conflict_miss", 32'(n > 0), 32'd1);
        fetch(32'h40, n);
        chk("evicted_refetch_miss", 32'(n > 0), 32'd1);

        // flush during a miss: fill lands, then everything is invalid
        flush_idle();
        forced_waits = 4;
        m_fill(32'h100); m_flush(); m_prefetch(32'h100);
        miss_pulse(32'h100);
        @(posedge CLK); #1 iflush = 1'b1;
        @(posedge CLK); #1 iflush = 1'b0;
        repeat (12) @(posedge CLK);
        #1 chk("flush_iren_dropped", 32'(iREN), 32'd0);
        forced_waits = -1;
        fetch(32'h100, n);
        chk("flush_refetch_miss", 32'(n > 0), 32'd1);

        // reset in the middle of a miss
        flush_idle();
        forced_waits = 5;
        fetch_q.push_back(32'h300);
        miss_pulse(32'h300);
        @(negedge CLK);
        chk("miss_iren_high", 32'(iREN), 32'd1);
        @(posedge CLK); #2 nRST = 1'b0;
        #1;
        chk("async_rst_iren", 32'(iREN), 32'd0);
        chk("async_rst_ihit", 32'(ihit), 32'd0);
        m_flush();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        forced_waits = -1;
        fetch(32'h300, n);
        chk("rst_refetch_miss", 32'(n > 0), 32'd1);

        // next-line behaviour (prefetch on or off)
        fetch(32'h200, n);
        fetch(32'h204, n);
        chk("next_line_hit", 32'(n == 0), 32'(PF));
        fetch(32'hFFFF_FFFC, n);
        fetch(32'h0000_0000, n);
        chk("wrap_next_line_hit", 32'(n == 0), 32'(PF));

        // randomized traffic with occasional idle flushes
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) flush_idle();
            a = pool[$urandom_range(0, 3)] + (32'($urandom_range(0, 23)) << 2) + 32'($urandom_range(0, 3));
            fetch(a, n);
        end

        repeat (10) @(posedge CLK);
        chk("resp_q_drained", resp_q.size(), 32'd0);
        chk("fetch_q_drained", fetch_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
